cozucu_denetleyici: RTL and testbench

- Top-level sequencer for the JPEG decode chain: huffman_decoder → zigzag_normalizer → dequantizer → icosine_transformer → decode_normalizer.
- Accepts a start command carrying the image size in 8x8 blocks and the compressed byte count.
- Meters the compressed byte stream into huffman_decoder.
- Counts reconstructed pixels leaving decode_normalizer, tags each with a raster frame-buffer address, and signals done/error.

---
 rtl/cozucu_denetleyici_pkg.sv | 17 +
 rtl/cozucu_denetleyici_if.sv | 60 ++++++
 rtl/cozucu_denetleyici_adres_uretec.sv | 95 +++++++++
 rtl/cozucu_denetleyici.sv | 134 +++++++++++++
 tb/tb_cozucu_denetleyici.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cozucu_denetleyici_pkg.sv
// Shared types and constants for the JPEG decode-chain sequencer.
package cozucu_denetleyici_pkg;

  localparam int unsigned BLOK_PIKSEL  = 64;
  localparam int unsigned DC_BOYUT_BIT = 8;
  localparam int unsigned WB_BIT       = 32;
  // Bits per in-block coordinate (8x8 block -> 3).
  localparam int unsigned KOORD_BIT    = $clog2(BLOK_PIKSEL) / 2;

  typedef enum logic [1:0] {
    DcBosta  = 2'b00,
    DcCalis  = 2'b01,
    DcBosalt = 2'b10,
    DcBitti  = 2'b11
  } dc_durum_e;

endpackage

// File: rtl/cozucu_denetleyici_if.sv
// Configuration, byte-stream and pixel-stream signals of the decode sequencer.
interface cozucu_denetleyici_if
  import cozucu_denetleyici_pkg::*;
#(
  parameter int unsigned ADR_BIT  = 22,
  parameter int unsigned BAYT_BIT = 24
);

  logic                    cfg_baslat_i;
  logic [DC_BOYUT_BIT-1:0] cfg_genislik_i;
  logic [DC_BOYUT_BIT-1:0] cfg_yukseklik_i;
  logic [BAYT_BIT-1:0]     cfg_bayt_sayisi_i;
  logic                    cfg_mesgul_o;
  logic                    cfg_bitti_o;
  logic                    cfg_hata_o;

  logic [7:0]              src_veri_i;
  logic                    src_gecerli_i;
  logic                    src_hazir_o;

  logic [WB_BIT-1:0]       hd_veri_o;
  logic                    hd_gecerli_o;
  logic                    hd_hazir_i;

  logic [7:0]              dn_veri_i;
  logic                    dn_gecerli_i;
  logic                    dn_hazir_o;

  logic [7:0]              px_veri_o;
  logic [ADR_BIT-1:0]      px_adr_o;
  logic                    px_gecerli_o;
  logic                    px_hazir_i;

  modport slave (
    input  cfg_baslat_i, cfg_genislik_i, cfg_yukseklik_i, cfg_bayt_sayisi_i,
    output cfg_mesgul_o, cfg_bitti_o, cfg_hata_o,
    input  src_veri_i, src_gecerli_i,
    output src_hazir_o,
    output hd_veri_o, hd_gecerli_o,
    input  hd_hazir_i,
    input  dn_veri_i, dn_gecerli_i,
    output dn_hazir_o,
    output px_veri_o, px_adr_o, px_gecerli_o,
    input  px_hazir_i
  );

  modport master (
    output cfg_baslat_i, cfg_genislik_i, cfg_yukseklik_i, cfg_bayt_sayisi_i,
    input  cfg_mesgul_o, cfg_bitti_o, cfg_hata_o,
    output src_veri_i, src_gecerli_i,
    input  src_hazir_o,
    input  hd_veri_o, hd_gecerli_o,
    output hd_hazir_i,
    output dn_veri_i, dn_gecerli_i,
    input  dn_hazir_o,
    input  px_veri_o, px_adr_o, px_gecerli_o,
    output px_hazir_i
  );

endinterface

// File: rtl/cozucu_denetleyici_adres_uretec.sv
// Raster frame-buffer address generator walking 8x8 blocks in raster order,
// using incremental row/block base registers instead of a multiplier.
module cozucu_denetleyici_adres_uretec
  import cozucu_denetleyici_pkg::*;
#(
  parameter int unsigned ADR_BIT = 22
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    temizle_i,
  input  logic                    ilerle_i,
  input  logic [DC_BOYUT_BIT-1:0] genislik_i,
  input  logic [DC_BOYUT_BIT-1:0] yukseklik_i,
  output logic [ADR_BIT-1:0]      adres_o,
  output logic                    son_piksel_o
);

  localparam logic [ADR_BIT-1:0] BlokAdim = ADR_BIT'(1 << KOORD_BIT);

  logic [KOORD_BIT-1:0]    c_q, c_d, r_q, r_d;
  logic [DC_BOYUT_BIT-1:0] bx_q, bx_d, by_q, by_d;
  logic [ADR_BIT-1:0]      satir_q, satir_d, blok_q, blok_d;
  logic [ADR_BIT-1:0]      satir_adim, blok_geri;
  logic                    son_c, son_r, son_bx, son_by;

  assign satir_adim = ADR_BIT'(genislik_i) << KOORD_BIT;
  // Seven pixel rows back: return from a block's last row to its first.
  assign blok_geri  = (satir_adim << KOORD_BIT) - satir_adim;

  assign son_c  = (c_q == '1);
  assign son_r  = (r_q == '1);
  assign son_bx = (bx_q == genislik_i - DC_BOYUT_BIT'(1));
  assign son_by = (by_q == yukseklik_i - DC_BOYUT_BIT'(1));

  assign adres_o      = satir_q + blok_q + ADR_BIT'(c_q);
  assign son_piksel_o = son_c && son_r && son_bx && son_by;

  always_comb begin
    c_d     = c_q;
    r_d     = r_q;
    bx_d    = bx_q;
    by_d    = by_q;
    satir_d = satir_q;
    blok_d  = blok_q;
    if (temizle_i) begin
      c_d     = '0;
      r_d     = '0;
      bx_d    = '0;
      by_d    = '0;
      satir_d = '0;
      blok_d  = '0;
    end else if (ilerle_i) begin
      if (!son_c) begin
        c_d = c_q + KOORD_BIT'(1);
      end else begin
        c_d = '0;
        if (!son_r) begin
          r_d     = r_q + KOORD_BIT'(1);
          satir_d = satir_q + satir_adim;
        end else begin
          r_d = '0;
          if (!son_bx) begin
            bx_d    = bx_q + DC_BOYUT_BIT'(1);
            blok_d  = blok_q + BlokAdim;
            satir_d = satir_q - blok_geri;
          end else begin
            bx_d    = '0;
            blok_d  = '0;
            by_d    = by_q + DC_BOYUT_BIT'(1);
            satir_d = satir_q + satir_adim;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_q     <= '0;
      r_q     <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      satir_q <= '0;
      blok_q  <= '0;
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      satir_q <= satir_d;
      blok_q  <= blok_d;
    end
  end

endmodule

// File: rtl/cozucu_denetleyici.sv
// Top-level sequencer of the JPEG decode chain: meters compressed bytes into the
// Huffman decoder and tags reconstructed pixels with raster frame-buffer addresses.
module cozucu_denetleyici
  import cozucu_denetleyici_pkg::*;
#(
  parameter int unsigned ADR_BIT  = 22,
  parameter int unsigned BAYT_BIT = 24
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  cozucu_denetleyici_if.slave  bus
);

  dc_durum_e               durum_q, durum_d;
  logic [DC_BOYUT_BIT-1:0] genislik_q, yukseklik_q;
  logic [BAYT_BIT-1:0]     bayt_sayisi_q, bayt_cnt_q, bayt_cnt_d;
  logic                    hata_q, hata_d;
  logic                    tum_alindi_q;
  logic [7:0]              px_veri_q;
  logic [ADR_BIT-1:0]      px_adr_q;
  logic                    px_gecerli_q, px_son_q;

  logic [ADR_BIT-1:0]      adres;
  logic                    son_piksel;
  logic                    calisiyor, acik, bayt_hs;
  logic                    dn_hazir, dn_hs, px_yukle, px_dusur, son_cikis;
  logic                    baslat_kabul, gecersiz_cfg;

  assign calisiyor    = (durum_q == DcCalis) || (durum_q == DcBosalt);
  assign acik         = (durum_q == DcCalis) && (bayt_cnt_q != bayt_sayisi_q);
  assign bayt_hs      = bus.src_gecerli_i && bus.hd_hazir_i && acik;
  assign bayt_cnt_d   = bayt_hs ? bayt_cnt_q + BAYT_BIT'(1) : bayt_cnt_q;

  assign dn_hazir     = !px_gecerli_q || bus.px_hazir_i;
  assign dn_hs        = bus.dn_gecerli_i && dn_hazir;
  // Pixels outside a frame, or past its last pixel, are swallowed and flagged.
  assign px_yukle     = dn_hs && calisiyor && !tum_alindi_q;
  assign px_dusur     = dn_hs && !px_yukle;
  assign son_cikis    = px_gecerli_q && bus.px_hazir_i && px_son_q;

  assign baslat_kabul = (durum_q == DcBosta) && bus.cfg_baslat_i;
  assign gecersiz_cfg = (bus.cfg_genislik_i == '0) || (bus.cfg_yukseklik_i == '0) ||
                        (bus.cfg_bayt_sayisi_i == '0);

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      DcBosta: begin
        if (bus.cfg_baslat_i) durum_d = gecersiz_cfg ? DcBitti : DcCalis;
      end
      DcCalis: begin
        if (son_cikis) durum_d = DcBitti;
        else if (bayt_cnt_d == bayt_sayisi_q) durum_d = DcBosalt;
      end
      DcBosalt: begin
        if (son_cikis) durum_d = DcBitti;
      end
      DcBitti: durum_d = DcBosta;
      default: durum_d = DcBosta;
    endcase
  end

  always_comb begin
    hata_d = hata_q;
    if (baslat_kabul) hata_d = gecersiz_cfg;
    if (px_dusur)     hata_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q       <= DcBosta;
      genislik_q    <= '0;
      yukseklik_q   <= '0;
      bayt_sayisi_q <= '0;
      bayt_cnt_q    <= '0;
      hata_q        <= 1'b0;
      tum_alindi_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      hata_q  <= hata_d;
      if (baslat_kabul) begin
        genislik_q    <= bus.cfg_genislik_i;
        yukseklik_q   <= bus.cfg_yukseklik_i;
        bayt_sayisi_q <= bus.cfg_bayt_sayisi_i;
        bayt_cnt_q    <= '0;
        tum_alindi_q  <= 1'b0;
      end else begin
        bayt_cnt_q <= bayt_cnt_d;
        if (px_yukle && son_piksel) tum_alindi_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      px_veri_q    <= '0;
      px_adr_q     <= '0;
      px_gecerli_q <= 1'b0;
      px_son_q     <= 1'b0;
    end else if (px_yukle) begin
      px_veri_q    <= bus.dn_veri_i;
      px_adr_q     <= adres;
      px_gecerli_q <= 1'b1;
      px_son_q     <= son_piksel;
    end else if (bus.px_hazir_i) begin
      px_gecerli_q <= 1'b0;
    end
  end

  cozucu_denetleyici_adres_uretec #(
    .ADR_BIT(ADR_BIT)
  ) u_adres (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .temizle_i    (baslat_kabul),
    .ilerle_i     (px_yukle),
    .genislik_i   (genislik_q),
    .yukseklik_i  (yukseklik_q),
    .adres_o      (adres),
    .son_piksel_o (son_piksel)
  );

  assign bus.cfg_mesgul_o = calisiyor;
  assign bus.cfg_bitti_o  = (durum_q == DcBitti);
  assign bus.cfg_hata_o   = hata_q;
  assign bus.src_hazir_o  = bus.hd_hazir_i && acik;
  assign bus.hd_gecerli_o = bus.src_gecerli_i && acik;
  assign bus.hd_veri_o    = {{(WB_BIT - 8){1'b0}}, bus.src_veri_i};
  assign bus.dn_hazir_o   = dn_hazir;
  assign bus.px_veri_o    = px_veri_q;
  assign bus.px_adr_o     = px_adr_q;
  assign bus.px_gecerli_o = px_gecerli_q;

endmodule

// File: tb/tb_cozucu_denetleyici.sv
// Randomized bench for cozucu_denetleyici with an arithmetic raster-address model.
module tb_cozucu_denetleyici;
  import cozucu_denetleyici_pkg::*;

  localparam int unsigned ADR_BIT  = 22;
  localparam int unsigned BAYT_BIT = 24;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cozucu_denetleyici_if #(.ADR_BIT(ADR_BIT), .BAYT_BIT(BAYT_BIT)) bus ();

  cozucu_denetleyici #(.ADR_BIT(ADR_BIT), .BAYT_BIT(BAYT_BIT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int r_bayt_hs, r_px_out, r_bitti, r_px_son_cyc, r_bitti_cyc;
  bit r_bosalt;
  int obs_adr[$];

  function automatic logic [ADR_BIT-1:0] ref_adr(input int k, input int w);
    int c, r, b, bx, by;
    c  = k % 8;
    r  = (k / 8) % 8;
    b  = k / 64;
    bx = b % w;
    by = b / w;
    return ADR_BIT'((by * 8 + r) * w * 8 + bx * 8 + c);
  endfunction

  task automatic idle_inputs();
    bus.cfg_baslat_i      = 1'b0;
    bus.cfg_genislik_i    = '0;
    bus.cfg_yukseklik_i   = '0;
    bus.cfg_bayt_sayisi_i = '0;
    bus.src_veri_i        = '0;
    bus.src_gecerli_i     = 1'b0;
    bus.hd_hazir_i        = 1'b1;
    bus.dn_veri_i         = '0;
    bus.dn_gecerli_i      = 1'b0;
    bus.px_hazir_i        = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [ADR_BIT+WB_BIT+13:0] all;
    all = {bus.cfg_mesgul_o, bus.cfg_bitti_o, bus.cfg_hata_o, bus.px_gecerli_o,
           bus.px_veri_o, bus.px_adr_o, bus.hd_gecerli_o, bus.src_hazir_o, bus.hd_veri_o};
    n_chk++;
    if (bus.cfg_mesgul_o !== 1'b0 || bus.cfg_bitti_o !== 1'b0 || bus.cfg_hata_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cfg: got mesgul=%b bitti=%b hata=%b want 0", tag, bus.cfg_mesgul_o,
               bus.cfg_bitti_o, bus.cfg_hata_o);
    end
    n_chk++;
    if (bus.px_gecerli_o !== 1'b0 || bus.px_veri_o !== 8'h00 || bus.px_adr_o !== '0) begin
      n_fail++;
      $display("FAIL %s px: got gecerli=%b veri=%h adr=%h want 0", tag, bus.px_gecerli_o,
               bus.px_veri_o, bus.px_adr_o);
    end
    n_chk++;
    if (bus.hd_gecerli_o !== 1'b0 || bus.src_hazir_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s byte: got hd_gecerli=%b src_hazir=%b want 0 (all=%h)", tag,
               bus.hd_gecerli_o, bus.src_hazir_o, all);
    end
  endtask

  task automatic start_frame(input int w, input int h, input int n);
    @(posedge clk); #1;
    bus.cfg_genislik_i    = 8'(w);
    bus.cfg_yukseklik_i   = 8'(h);
    bus.cfg_bayt_sayisi_i = BAYT_BIT'(n);
    bus.cfg_baslat_i      = 1'b1;
    @(posedge clk); #1;
    bus.cfg_baslat_i      = 1'b0;
  endtask

  // hz_mod: 0 = px_hazir always 1, 1 = toggling, 2 = random (also randomizes hd_hazir).
  task automatic run_frame(input int w, input int h, input int n, input int nsrc,
                           input int hz_mod, input int dn_pct, input int extra,
                           input int abort_px);
    int total, budget, dn_sent, bhs, cyc, tail;
    logic [7:0] bytes[$];
    logic [7:0] exp_v[$];
    logic [ADR_BIT-1:0] exp_a[$];
    logic stall_prev, dn_acc;
    logic [7:0] sv, ev;
    logic [ADR_BIT-1:0] sa, ea;
    total = w * h * 64;
    budget = ((total + extra) * 100 / dn_pct) * 3 + 300;
    dn_sent = 0; bhs = 0; cyc = 0; tail = 0;
    stall_prev = 1'b0; sv = '0; sa = '0; dn_acc = 1'b0;
    r_bayt_hs = 0; r_px_out = 0; r_bitti = 0; r_px_son_cyc = -1; r_bitti_cyc = -1;
    r_bosalt = 1'b0;
    obs_adr.delete();
    for (int i = 0; i < nsrc; i++) bytes.push_back(8'($urandom));
    start_frame(w, h, n);
    bus.src_gecerli_i = (nsrc > 0);
    bus.src_veri_i    = (nsrc > 0) ? bytes[0] : 8'h00;
    bus.dn_gecerli_i  = (total > 0);
    bus.dn_veri_i     = 8'($urandom);
    bus.px_hazir_i    = 1'b1;
    bus.hd_hazir_i    = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bhs >= n) begin
        n_chk++;
        if (bus.src_hazir_o !== 1'b0 || bus.hd_gecerli_o !== 1'b0) begin
          n_fail++;
          $display("FAIL byte_kapali: got src_hazir=%b hd_gecerli=%b want 0 after %0d bytes",
                   bus.src_hazir_o, bus.hd_gecerli_o, bhs);
        end
      end
      if (bus.src_gecerli_i && bus.src_hazir_o) begin
        n_chk++;
        if (bus.hd_gecerli_o !== 1'b1 || bus.hd_veri_o !== WB_BIT'(bytes[bhs])) begin
          n_fail++;
          $display("FAIL hd_veri: got gecerli=%b veri=%h want 1/%h", bus.hd_gecerli_o,
                   bus.hd_veri_o, WB_BIT'(bytes[bhs]));
        end
        bhs++;
      end
      if (stall_prev) begin
        n_chk++;
        if (bus.px_gecerli_o !== 1'b1 || bus.px_veri_o !== sv || bus.px_adr_o !== sa) begin
          n_fail++;
          $display("FAIL px_stall: got %b/%h/%h want 1/%h/%h", bus.px_gecerli_o,
                   bus.px_veri_o, bus.px_adr_o, sv, sa);
        end
      end
      if (bus.px_gecerli_o && !bus.px_hazir_i) begin
        n_chk++;
        if (bus.dn_hazir_o !== 1'b0) begin
          n_fail++;
          $display("FAIL dn_hazir_stall: got %b want 0", bus.dn_hazir_o);
        end
      end
      if (bus.px_gecerli_o && bus.px_hazir_i) begin
        n_chk++;
        if (exp_v.size() == 0) begin
          n_fail++;
          $display("FAIL px_fazla: got pixel adr=%h want none", bus.px_adr_o);
        end else begin
          ev = exp_v.pop_front();
          ea = exp_a.pop_front();
          if (bus.px_veri_o !== ev || bus.px_adr_o !== ea) begin
            n_fail++;
            $display("FAIL px_%0d: got veri=%h adr=%0d want veri=%h adr=%0d", r_px_out,
                     bus.px_veri_o, bus.px_adr_o, ev, ea);
          end
        end
        obs_adr.push_back(int'(bus.px_adr_o));
        r_px_out++;
        if (r_px_out == total) r_px_son_cyc = cyc;
      end
      dn_acc = bus.dn_gecerli_i && bus.dn_hazir_o;
      if (dn_acc) begin
        if (dn_sent < total) begin
          exp_v.push_back(bus.dn_veri_i);
          exp_a.push_back(ref_adr(dn_sent, w));
        end
        dn_sent++;
      end
      if (bus.cfg_bitti_o) begin
        r_bitti++;
        r_bitti_cyc = cyc;
      end
      if (bhs >= n && bus.cfg_mesgul_o && r_px_out < total && !bus.src_hazir_o) r_bosalt = 1'b1;
      stall_prev = bus.px_gecerli_o && !bus.px_hazir_i;
      sv = bus.px_veri_o;
      sa = bus.px_adr_o;
      if (abort_px > 0 && r_px_out >= abort_px) break;
      if (r_bitti > 0 && dn_sent >= total + extra) begin
        tail++;
        if (tail > 2) break;
      end
      if (cyc > budget) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: got %0d pixels %0d bitti want %0d pixels 1 bitti", r_px_out,
                 r_bitti, total);
        break;
      end
      @(posedge clk); #1;
      bus.src_gecerli_i = (bhs < nsrc);
      bus.src_veri_i    = (bhs < nsrc) ? bytes[bhs] : 8'h00;
      if (!(bus.dn_gecerli_i && !dn_acc)) begin
        if (dn_sent < total + extra && int'($urandom_range(99)) < dn_pct) begin
          bus.dn_gecerli_i = 1'b1;
          bus.dn_veri_i    = 8'($urandom);
        end else begin
          bus.dn_gecerli_i = 1'b0;
        end
      end
      case (hz_mod)
        0: bus.px_hazir_i = 1'b1;
        1: bus.px_hazir_i = ~bus.px_hazir_i;
        default: begin
          bus.px_hazir_i = ($urandom_range(3) != 0);
          bus.hd_hazir_i = ($urandom_range(3) != 0);
        end
      endcase
    end
    r_bayt_hs = bhs;
    if (abort_px == 0) begin
      n_chk++;
      if (exp_v.size() != 0) begin
        n_fail++;
        $display("FAIL px_kayip: got %0d pixels pending want 0", exp_v.size());
      end
      bus.src_gecerli_i = 1'b0;
      bus.dn_gecerli_i  = 1'b0;
      bus.px_hazir_i    = 1'b1;
      bus.hd_hazir_i    = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int px, input int bayt, input int hata);
    n_chk++;
    if (r_px_out != px) begin
      n_fail++;
      $display("FAIL %s px_sayi: got %0d want %0d", tag, r_px_out, px);
    end
    n_chk++;
    if (r_bayt_hs != bayt) begin
      n_fail++;
      $display("FAIL %s bayt_sayi: got %0d want %0d", tag, r_bayt_hs, bayt);
    end
    n_chk++;
    if (r_bitti != 1) begin
      n_fail++;
      $display("FAIL %s bitti_sayi: got %0d want 1", tag, r_bitti);
    end
    n_chk++;
    if (bus.cfg_hata_o !== 1'(hata)) begin
      n_fail++;
      $display("FAIL %s hata: got %b want %0d", tag, bus.cfg_hata_o, hata);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_adres();
    int want_idx[6] = '{0, 7, 8, 63, 64, 127};
    int want_adr[6] = '{0, 7, 16, 119, 8, 127};
    run_frame(2, 1, 6, 6, 0, 100, 0, 0);
    check_frame("adres", 128, 6, 0);
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs_adr.size() <= want_idx[i] || obs_adr[want_idx[i]] != want_adr[i]) begin
        n_fail++;
        $display("FAIL adres_%0d: got %0d want %0d", want_idx[i],
                 (obs_adr.size() > want_idx[i]) ? obs_adr[want_idx[i]] : -1, want_adr[i]);
      end
    end
    n_chk++;
    if (r_bitti_cyc != r_px_son_cyc + 1) begin
      n_fail++;
      $display("FAIL bitti_zaman: got cycle %0d want %0d", r_bitti_cyc, r_px_son_cyc + 1);
    end
  endtask

  task automatic test_bayt_limit();
    run_frame(1, 1, 3, 6, 0, 30, 0, 0);
    check_frame("bayt_limit", 64, 3, 0);
    n_chk++;
    if (r_bosalt !== 1'b1) begin
      n_fail++;
      $display("FAIL bosalt: got %b want 1", r_bosalt);
    end
  endtask

  task automatic test_stall();
    run_frame(2, 1, 4, 4, 1, 100, 0, 0);
    check_frame("stall", 128, 4, 0);
  endtask

  task automatic test_sifir_boyut();
    int bhs, nb, bcyc;
    bhs = 0; nb = 0; bcyc = -1;
    bus.src_gecerli_i = 1'b1;
    bus.src_veri_i    = 8'h5a;
    start_frame(0, 2, 5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.src_gecerli_i && bus.src_hazir_o) bhs++;
      if (bus.cfg_bitti_o) begin
        nb++;
        bcyc = k;
      end
    end
    bus.src_gecerli_i = 1'b0;
    n_chk++;
    if (bhs != 0) begin
      n_fail++;
      $display("FAIL sifir_bayt: got %0d want 0", bhs);
    end
    n_chk++;
    if (nb != 1 || bcyc != 1) begin
      n_fail++;
      $display("FAIL sifir_bitti: got %0d pulses at %0d want 1 at 1", nb, bcyc);
    end
    n_chk++;
    if (bus.cfg_hata_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sifir_hata: got %b want 1", bus.cfg_hata_o);
    end
  endtask

  task automatic test_bosta_hata();
    @(posedge clk); #1;
    bus.dn_gecerli_i = 1'b1;
    bus.dn_veri_i    = 8'($urandom);
    @(negedge clk);
    n_chk++;
    if (bus.dn_hazir_o !== 1'b1 || bus.px_gecerli_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bosta_dn: got hazir=%b px_gecerli=%b want 1/0", bus.dn_hazir_o,
               bus.px_gecerli_o);
    end
    @(posedge clk); #1;
    bus.dn_gecerli_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.cfg_hata_o !== 1'b1 || bus.px_gecerli_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bosta_hata: got hata=%b px_gecerli=%b want 1/0", bus.cfg_hata_o,
               bus.px_gecerli_o);
    end
    run_frame(1, 1, 2, 2, 2, 80, 0, 0);
    check_frame("bosta_sonra", 64, 2, 0);
  endtask

  task automatic test_reset_ortasi();
    run_frame(2, 2, 10, 10, 2, 90, 0, 40);
    n_chk++;
    if (r_px_out != 40) begin
      n_fail++;
      $display("FAIL reset_once: got %0d pixels want 40", r_px_out);
    end
    #2;
    rstn = 1'b0;
    #1;
    check_outputs_zero("reset_ortasi");
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    run_frame(1, 1, 1, 1, 0, 100, 0, 0);
    check_frame("reset_sonra", 64, 1, 0);
    n_chk++;
    if (obs_adr.size() == 0 || obs_adr[0] != 0) begin
      n_fail++;
      $display("FAIL reset_adr0: got %0d want 0", (obs_adr.size() > 0) ? obs_adr[0] : -1);
    end
  endtask

  task automatic test_random();
    int w, h, n, nsrc, extra;
    for (int i = 0; i < 4; i++) begin
      w     = int'($urandom_range(1, 3));
      h     = int'($urandom_range(1, 3));
      n     = int'($urandom_range(1, 12));
      nsrc  = int'($urandom_range(0, 15));
      extra = (i == 3) ? 1 : 0;
      run_frame(w, h, n, nsrc, 2, int'($urandom_range(40, 100)), extra, 0);
      check_frame("random", w * h * 64, (nsrc < n) ? nsrc : n, extra);
    end
  endtask

  initial begin
    test_reset();
    test_adres();
    test_bayt_limit();
    test_stall();
    test_sifir_boyut();
    test_bosta_hata();
    test_reset_ortasi();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
